// File: rtl/multi_tone_output.sv
// Multi-channel DDS tone generator: per-channel phase accumulator, quarter-wave sine lookup,
// linear amplitude ramp and a saturating summer driving one signed output.
module multi_tone_output #(
   parameter int N_TONE        = 4,
   parameter int OUT_W         = 14,
   parameter int FREQ_W        = 16,
   parameter int PINC_PER_UNIT = 2147,
   parameter int RAMP_STEP     = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic                    cfg_valid_i,
   output logic                    cfg_ready_o,
   input  logic [2:0]              cfg_ch_i,
   input  logic [FREQ_W-1:0]       cfg_freq_i,
   input  logic [15:0]             cfg_amp_i,
   input  logic [9:0]              cfg_phase_i,
   output logic signed [OUT_W-1:0] sig_out_o,
   output logic                    busy_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   localparam int                       SUM_W   = OUT_W + 4;
   localparam int                       PEAK    = (1 << (OUT_W - 1)) - 1;
   localparam logic [31:0]              PINC    = 32'(PINC_PER_UNIT);
   localparam logic [15:0]              STEP16  = 16'(RAMP_STEP);
   localparam logic signed [SUM_W-1:0]  SUM_MAX = SUM_W'(PEAK);
   localparam logic signed [SUM_W-1:0]  SUM_MIN = ~SUM_MAX;

   // Rounded PEAK*sin(pi*idx/512) for idx in 0..256, evaluated with a Q30 Taylor series.
   function automatic logic [OUT_W-2:0] quarter_sine(input int idx);
      longint x;
      longint x2;
      longint term;
      longint acc;
      longint mag;
      x    = (64'sd3373259426 * longint'(idx)) >>> 9;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int k = 1; k <= 6; k++) begin
         term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      mag = (acc * longint'(PEAK) + (64'sd1 <<< 29)) >>> 30;
      if (mag > longint'(PEAK)) mag = longint'(PEAK);
      if (mag < 64'sd0)         mag = 64'sd0;
      return (OUT_W - 1)'(mag);
   endfunction

   logic [OUT_W-2:0] qrom [0:256];
   for (genvar gi = 0; gi <= 256; gi++) begin : g_rom
      assign qrom[gi] = quarter_sine(gi);
   end

   logic [1:0]              state_q, state_d;
   logic                    start_run;
   logic [N_TONE-1:0]       amp_zero;
   logic [N_TONE*OUT_W-1:0] prod_flat;
   logic signed [SUM_W-1:0] sum_wide;
   logic signed [OUT_W-1:0] sum_q, sum_d;

   assign start_run = (state_q == ST_IDLE) && en_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en_i) state_d = ST_RUN;
         ST_RUN:  if (!en_i) state_d = ST_STOP;
         ST_STOP: begin
            if (en_i)           state_d = ST_RUN;
            else if (&amp_zero) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   for (genvar gi = 0; gi < N_TONE; gi++) begin : g_ch
      logic [FREQ_W-1:0]       freq_q;
      logic [15:0]             tgt_q;
      logic [9:0]              phase_q;
      logic [31:0]             acc_q, acc_d;
      logic [15:0]             amp_q, amp_d, amp_goal;
      logic signed [OUT_W-1:0] lut_q, lut_d;
      logic signed [OUT_W-1:0] prod_q, prod_d;
      logic signed [OUT_W+16:0] mult;
      logic                    cfg_hit;
      logic [9:0]              ph;
      logic [8:0]              rom_addr;
      logic [OUT_W-2:0]        mag;

      assign cfg_hit = cfg_valid_i && (cfg_ch_i == 3'(gi));

      // Start phase is applied only on a fresh start; a resumed tone keeps its phase.
      always_comb begin
         acc_d = acc_q;
         if (start_run)               acc_d = {phase_q, 22'b0};
         else if (state_q != ST_IDLE) acc_d = acc_q + 32'(freq_q) * PINC;
      end

      assign amp_goal = (state_q == ST_RUN) ? tgt_q : 16'd0;

      always_comb begin
         amp_d = amp_q;
         if (amp_q < amp_goal) begin
            if ((amp_goal - amp_q) > STEP16) amp_d = amp_q + STEP16;
            else                             amp_d = amp_goal;
         end else if (amp_q > amp_goal) begin
            if ((amp_q - amp_goal) > STEP16) amp_d = amp_q - STEP16;
            else                             amp_d = amp_goal;
         end
      end

      // Quadrant folding: odd quadrants mirror the index, the upper half negates.
      assign ph       = acc_q[31:22];
      assign rom_addr = ph[8] ? (9'd256 - {1'b0, ph[7:0]}) : {1'b0, ph[7:0]};
      assign mag      = qrom[rom_addr];
      assign lut_d    = ph[9] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

      assign mult   = $signed(lut_q) * $signed({1'b0, amp_q});
      assign prod_d = OUT_W'(mult >>> 16);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            freq_q  <= '0;
            tgt_q   <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            amp_q   <= '0;
            lut_q   <= '0;
            prod_q  <= '0;
         end else begin
            if (cfg_hit) begin
               freq_q  <= cfg_freq_i;
               tgt_q   <= cfg_amp_i;
               phase_q <= cfg_phase_i;
            end
            acc_q  <= acc_d;
            amp_q  <= amp_d;
            lut_q  <= lut_d;
            prod_q <= prod_d;
         end
      end

      assign amp_zero[gi]                   = (amp_q == 16'd0);
      assign prod_flat[gi*OUT_W +: OUT_W]   = prod_q;
   end

   always_comb begin
      sum_wide = '0;
      for (int i = 0; i < N_TONE; i++) begin
         sum_wide = sum_wide + SUM_W'($signed(prod_flat[i*OUT_W +: OUT_W]));
      end
      if (sum_wide > SUM_MAX)      sum_d = SUM_MAX[OUT_W-1:0];
      else if (sum_wide < SUM_MIN) sum_d = SUM_MIN[OUT_W-1:0];
      else                         sum_d = sum_wide[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum_d;
   end

   assign sig_out_o   = (state_q == ST_IDLE) ? '0 : sum_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign cfg_ready_o = 1'b1;

endmodule

// File: doc/multi_tone_output.md
MULTI_TONE_OUTPUT -- requirements
Module: multi_tone_output

Interface
REQ-001 Parameter N_TONE, default 4: number of independent tone channels, range 1..8.
REQ-002 Parameter OUT_W, default 14: signed output and sine-sample width.
REQ-003 Parameter FREQ_W, default 16: frequency word width, in units of 25 Hz.
REQ-004 Parameter PINC_PER_UNIT, default 2147: phase increment per frequency unit (32-bit accumulator, 50 MHz clk).
REQ-005 Parameter RAMP_STEP, default 64: amplitude change per clk while ramping.
REQ-006 clk  in  1  system clock; all state on posedge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  level; 1 = run tones, 0 = ramp down and stop.
REQ-009 cfg_valid  in  1  configuration write request.
REQ-010 cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready at posedge.
REQ-011 cfg_ch  in  3  target channel index; values >= N_TONE are accepted and ignored.
REQ-012 cfg_freq  in  FREQ_W  channel frequency, unsigned.
REQ-013 cfg_amp  in  16  channel target amplitude, unsigned, 65535 = full scale.
REQ-014 cfg_phase  in  10  channel start phase, 1024 steps per cycle.
REQ-015 sig_out  out  OUT_W  signed saturated sum of all channels.
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 Controller states: IDLE, RUN, STOP; IDLE->RUN when en=1; RUN->STOP when en=0; STOP->IDLE when all current amplitudes reach 0; STOP->RUN when en=1.
REQ-018 Entry into RUN from IDLE loads each accumulator with {cfg_phase_reg, 22'b0}, where cfg_phase_reg is the stored start phase; the accumulator is not reloaded on STOP->RUN.
REQ-019 In RUN and STOP, each accumulator adds freq_reg*PINC_PER_UNIT (32-bit, modulo 2^32) every clk; in IDLE, accumulators hold.
REQ-020 Sine lookup uses the top 10 accumulator bits; quarter-wave table; peak magnitude 2^(OUT_W-1)-1; output is symmetric (sample at phase p+512 = -sample at p).
REQ-021 Per channel, current amplitude moves toward its target by RAMP_STEP per clk and lands exactly on the target without overshoot; in STOP, the target is forced to 0.
REQ-022 Channel product = (sine * current_amp) >>> 16, arithmetic shift, truncate toward -inf.
REQ-023 Pipeline: accumulator -> LUT register -> product register -> sum/saturate register; sig_out lags accumulator phase by exactly 3 clk.
REQ-024 Sum is computed at OUT_W+4 bits and clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
REQ-025 cfg_ready = 1 in every state; an accepted write updates freq_reg, target amp and cfg_phase_reg of cfg_ch at the next posedge; a new freq takes effect on the following accumulator add.
REQ-026 If en falls and a cfg write occurs in the same cycle, both take effect; STOP still forces the target to 0, and the written amp is retained for the next RUN.
REQ-027 In IDLE, sig_out = 0 regardless of pipeline contents.

Reset
REQ-028 On rst=0: state IDLE; all accumulators, freq_reg, amplitudes, targets, cfg_phase_reg and pipeline registers = 0; sig_out = 0; busy = 0; cfg_ready = 1.
REQ-029 Reset asserted mid-RUN clears everything immediately, with no ramp-down; after release, the block waits in IDLE for en.

Verification
REQ-030 Reset during RUN with sig_out != 0 -> sig_out = 0, busy = 0 within the same cycle; no output until en is reasserted.
REQ-031 ch0 freq = 1, amp = 0, en = 1 -> accumulator steps 2147 per clk; sig_out stays 0; busy = 1.
REQ-032 ch0 amp 0 -> 65535 in RUN -> current amp reaches 65472 after 1023 clk and 65535 at clk 1024, never exceeding 65535.
REQ-033 ch0 and ch1 freq = 0, phase = 256, amp = 65535 -> each product = 8190; sig_out = 8191 (saturated) 3 clk after RUN entry plus ramp completion.
REQ-034 Tone running at amp 65535, en -> 0 -> ramp reaches 0 after 1024 clk; state = IDLE; busy = 0 on the next clk.
REQ-035 cfg_ch = 5 with N_TONE = 4 -> handshake completes; no channel register changes.
